prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 Parameter N, default 18, number of prescaler bits; legal range 1..24.
REQ-002 Parameter WIDTH, default 8, counter width in bits; legal range 1..32.
REQ-003 The block SHALL expose the following ports.
- CLK: input, 1 bit, single system clock; all state is updated on its rising edge.
- RST: input, 1 bit, synchronous active-high reset.
- EN: input, 1 bit, count enable; when low, the prescaler and counter hold.
- MODE: input, 2 bits; 00 = up-wrap, 01 = down-wrap, 10 = ping-pong, 11 = hold.
- LIMIT: input, WIDTH bits, terminal value; the count range is 0..LIMIT.
- LOAD: input, 1 bit, synchronous load strobe.
- DIN: input, WIDTH bits, value loaded when LOAD is high.
- Q: output, WIDTH bits, registered count value.
- TICK: output, 1 bit, registered one-cycle prescaler strobe.
- TC: output, 1 bit, registered one-cycle terminal-count pulse.

Function
REQ-004 The prescaler SHALL be an N-bit register that increments by 1 modulo 2^N on every CLK edge where EN=1 and LOAD=0.
REQ-005 An internal step SHALL occur on an edge where EN=1, LOAD=0 and prescaler = 2^N-1; TICK SHALL be 1 in the cycle after each step and 0 otherwise.
- Consequence: with EN held high, steps occur every 2^N cycles.
REQ-006 LOAD=1 SHALL take priority over stepping, regardless of EN.
- Q <= DIN, prescaler <= 0, TC <= 0.
- In ping-pong mode the direction is set to up.
REQ-007 Up-wrap, on a step: if Q >= LIMIT then Q <= 0 and TC pulses; else Q <= Q+1.
REQ-008 Down-wrap, on a step: if Q = 0 then Q <= LIMIT and TC pulses; if Q > LIMIT then Q <= LIMIT with no TC; else Q <= Q-1.
REQ-009 Ping-pong SHALL use an internal direction bit, which resets to up.
- Direction up, on a step: if Q >= LIMIT then Q <= LIMIT-1 (saturating at 0), direction <= down, and TC pulses; else Q <= Q+1.
- Direction down, on a step: if Q = 0 then Q <= 1 (saturating at LIMIT), direction <= up, and TC pulses; else Q <= Q-1.
REQ-010 When LIMIT = 0, Q SHALL remain 0 in every mode, and TC SHALL pulse on every step.
REQ-011 Hold mode (11) SHALL keep Q and the direction bit unchanged; the prescaler and TICK SHALL keep running; TC SHALL stay 0.
REQ-012 A MODE change SHALL take effect at the next step; Q SHALL NOT be altered at the moment of the change.
REQ-013 When EN=0, Q, the prescaler and the direction bit SHALL hold, and TICK and TC SHALL be 0.
REQ-014 LIMIT SHALL be sampled only on step edges; changing LIMIT between steps SHALL have no other effect.
REQ-015 All arithmetic SHALL be WIDTH-bit unsigned; Q SHALL never hold a value outside 0..2^WIDTH-1.
REQ-016 TC SHALL be registered and SHALL be high in exactly the cycle in which the Q value it refers to first appears.

Reset
REQ-017 On an edge with RST=1, the block SHALL set prescaler = 0, Q = 0, TICK = 0, TC = 0 and direction = up.
REQ-018 RST SHALL take priority over LOAD and EN.
REQ-019 RST asserted mid-count SHALL restart the 2^N-cycle prescaler period from 0 on the first edge after RST falls.

Verification
All scenarios use N=2 and WIDTH=4 (step every 4 cycles).
REQ-020 Up-wrap, LIMIT=5, EN=1, after reset -> Q sequence 1,2,3,4,5,0,1 at 4-cycle spacing; TC high only with Q=0; TICK high every 4th cycle.
REQ-021 Down-wrap, LIMIT=3, Q loaded to 9 -> Q sequence 3,2,1,0,3; TC high only on the 0 -> 3 transition.
REQ-022 Ping-pong, LIMIT=3, from reset -> Q sequence 1,2,3,2,1,0,1; TC high on the 3 -> 2 and 0 -> 1 transitions.
REQ-023 LOAD=1 with DIN=7 asserted in the same cycle as a step -> Q=7, TC=0, and the next step occurs exactly 4 cycles later.
REQ-024 EN dropped for 10 cycles mid-period -> Q, TICK and TC frozen; the step resumes after the remaining prescaler count with no lost or extra step.
REQ-025 RST pulsed while Q=6 in ping-pong moving down -> Q=0, direction up; the first step after release gives Q=1 four cycles after RST falls.

Source files
------------

// File: rtl/prescaled_counter.sv
// ---------------------------------------------------------------------------
// prescaled_counter
//
// Purpose:
//   Counter whose count advances once every 2^N clock cycles. An N-bit
//   free-running prescaler produces an internal "step" when it reaches its
//   all-ones value. On each step the WIDTH-bit count Q moves according to
//   MODE:
//     00 up-wrap    : 0..LIMIT, wraps to 0 and pulses TC
//     01 down-wrap  : LIMIT..0, wraps to LIMIT and pulses TC
//     10 ping-pong  : bounces between 0 and LIMIT, pulsing TC at each turn
//     11 hold       : Q frozen, prescaler and TICK keep running
//   A synchronous LOAD overrides stepping and restarts the prescaler period.
//
// Ports:
//   CLK    in   1      system clock, all state updates on the rising edge
//   RST    in   1      synchronous active-high reset (highest priority)
//   EN     in   1      count enable; low freezes prescaler, Q and direction
//   MODE   in   2      counting mode, see above
//   LIMIT  in   WIDTH  terminal value, sampled only on step edges
//   LOAD   in   1      synchronous load strobe (priority over stepping)
//   DIN    in   WIDTH  value loaded into Q when LOAD is high
//   Q      out  WIDTH  registered count value
//   TICK   out  1      registered one-cycle strobe following each step
//   TC     out  1      registered one-cycle terminal-count pulse, high in the
//                      same cycle as the Q value it refers to
// ---------------------------------------------------------------------------
module prescaled_counter #(
    parameter int N     = 18,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] LIMIT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] Q,
    output logic             TICK,
    output logic             TC
);

    // Parameter legality is enforced at elaboration time.
    if (N < 1 || N > 24) begin : g_bad_n
        $error("prescaled_counter: N must be in 1..24");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("prescaled_counter: WIDTH must be in 1..32");
    end

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Outcome of one step: new count, terminal-count flag, new direction.
    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             tc;
        dir_t             dir;
    } step_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [N-1:0]     PRE_ONE  = N'(1);

    // LIMIT-1, clamped at 0 so a zero limit cannot underflow.
    function automatic logic [WIDTH-1:0] dec_sat0(input logic [WIDTH-1:0] v);
        return (v == CNT_ZERO) ? CNT_ZERO : (v - CNT_ONE);
    endfunction

    // The value 1, clamped to LIMIT so a zero limit keeps Q at 0.
    function automatic logic [WIDTH-1:0] one_sat(input logic [WIDTH-1:0] lim);
        return (lim == CNT_ZERO) ? CNT_ZERO : CNT_ONE;
    endfunction

    // Next count/TC/direction for a step edge, given the sampled LIMIT.
    function automatic step_t next_on_step(input mode_t            mode,
                                           input dir_t             dir,
                                           input logic [WIDTH-1:0] q,
                                           input logic [WIDTH-1:0] lim);
        step_t r;
        r.q   = q;
        r.tc  = 1'b0;
        r.dir = dir;
        if (mode != MODE_HOLD && lim == CNT_ZERO) begin
            // A zero-length range pins Q at 0 and every step is terminal,
            // even when a load left Q above the limit. Ping-pong still
            // turns around so the direction bit keeps its bounce rhythm.
            r.q  = CNT_ZERO;
            r.tc = 1'b1;
            if (mode == MODE_PINGPONG) begin
                r.dir = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
            end
        end else begin
            unique case (mode)
                MODE_UP: begin
                    if (q >= lim) begin
                        r.q  = CNT_ZERO;
                        r.tc = 1'b1;
                    end else begin
                        r.q = q + CNT_ONE;
                    end
                end
                MODE_DOWN: begin
                    if (q == CNT_ZERO) begin
                        r.q  = lim;
                        r.tc = 1'b1;
                    end else if (q > lim) begin
                        // Out-of-range value after a load snaps to the top
                        // without counting as a wrap.
                        r.q = lim;
                    end else begin
                        r.q = q - CNT_ONE;
                    end
                end
                MODE_PINGPONG: begin
                    if (dir == DIR_UP) begin
                        if (q >= lim) begin
                            r.q   = dec_sat0(lim);
                            r.dir = DIR_DOWN;
                            r.tc  = 1'b1;
                        end else begin
                            r.q = q + CNT_ONE;
                        end
                    end else begin
                        if (q == CNT_ZERO) begin
                            r.q   = one_sat(lim);
                            r.dir = DIR_UP;
                            r.tc  = 1'b1;
                        end else begin
                            r.q = q - CNT_ONE;
                        end
                    end
                end
                MODE_HOLD: begin
                    r.q = q;
                end
            endcase
        end
        return r;
    endfunction

    logic [N-1:0]     pre_p1;
    logic [WIDTH-1:0] cnt_p1;
    dir_t             dir_p1;
    logic             vld_p1;
    logic             tc_p1;

    logic [N-1:0]     pre_d;
    logic [WIDTH-1:0] cnt_d;
    dir_t             dir_d;
    logic             tc_d;
    logic             vld_p0;
    step_t            res_p0;

    // ---- stage p0: step decode and next-state selection ----
    always_comb begin
        pre_d  = pre_p1;
        cnt_d  = cnt_p1;
        dir_d  = dir_p1;
        tc_d   = 1'b0;
        vld_p0 = EN && !LOAD && (&pre_p1);
        res_p0 = next_on_step(mode_t'(MODE), dir_p1, cnt_p1, LIMIT);

        if (LOAD) begin
            // Load wins over a coincident step and restarts the period.
            cnt_d = DIN;
            pre_d = '0;
            if (mode_t'(MODE) == MODE_PINGPONG) begin
                dir_d = DIR_UP;
            end
        end else if (EN) begin
            pre_d = pre_p1 + PRE_ONE;
            if (vld_p0) begin
                cnt_d = res_p0.q;
                tc_d  = res_p0.tc;
                dir_d = res_p0.dir;
            end
        end
    end

    // ---- stage p1: registered state and outputs ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_p1 <= '0;
            cnt_p1 <= '0;
            dir_p1 <= DIR_UP;
            vld_p1 <= 1'b0;
            tc_p1  <= 1'b0;
        end else begin
            pre_p1 <= pre_d;
            cnt_p1 <= cnt_d;
            dir_p1 <= dir_d;
            vld_p1 <= vld_p0;
            tc_p1  <= tc_d;
        end
    end

    assign Q    = cnt_p1;
    assign TICK = vld_p1;
    assign TC   = tc_p1;

endmodule

// File: tb/tb_prescaled_counter.sv
module tb_prescaled_counter;

    localparam int N     = 2;
    localparam int WIDTH = 4;
    localparam int PERIOD = 4; // 2^N

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN = 1'b0;
    logic [1:0]       MODE = 2'b00;
    logic [WIDTH-1:0] LIMIT = '0;
    logic             LOAD = 1'b0;
    logic [WIDTH-1:0] DIN = '0;
    logic [WIDTH-1:0] Q;
    logic             TICK;
    logic             TC;

    always #5 CLK = ~CLK;

    prescaled_counter #(.N(N), .WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .MODE (MODE),
        .LIMIT(LIMIT),
        .LOAD (LOAD),
        .DIN  (DIN),
        .Q    (Q),
        .TICK (TICK),
        .TC   (TC)
    );

    typedef struct {
        int q;
        int tick;
        int tc;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: prescaler phase as an integer modulo 2^N,
    // count as a plain integer, direction 0 = up, 1 = down.
    int m_phase = 0;
    int m_q     = 0;
    int m_dir   = 0;
    int m_tick  = 0;
    int m_tc    = 0;

    task automatic check(input string nm, input int c, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, c, act, req);
        end
    endtask

    function automatic void model_edge(input int rst, input int en, input int load,
                                       input int mode, input int lim, input int din);
        int top;
        if (rst != 0) begin
            m_phase = 0; m_q = 0; m_dir = 0; m_tick = 0; m_tc = 0;
            return;
        end
        m_tick = 0;
        m_tc   = 0;
        if (load != 0) begin
            m_q = din;
            m_phase = 0;
            if (mode == 2) m_dir = 0;
            return;
        end
        if (en == 0) return;
        top = (m_phase == PERIOD - 1);
        m_phase = (m_phase + 1) % PERIOD;
        if (!top) return;
        m_tick = 1;
        if (mode == 3) return;
        if (lim == 0) begin
            m_q = 0; m_tc = 1;
            if (mode == 2) m_dir = 1 - m_dir;
            return;
        end
        case (mode)
            0: if (m_q >= lim) begin m_q = 0; m_tc = 1; end else m_q = m_q + 1;
            1: if (m_q == 0) begin m_q = lim; m_tc = 1; end
               else if (m_q > lim) m_q = lim;
               else m_q = m_q - 1;
            default: begin
                if (m_dir == 0) begin
                    if (m_q >= lim) begin m_q = lim - 1; m_dir = 1; m_tc = 1; end
                    else m_q = m_q + 1;
                end else begin
                    if (m_q == 0) begin m_q = 1; m_dir = 0; m_tc = 1; end
                    else m_q = m_q - 1;
                end
            end
        endcase
    endfunction

    // One clock: drive inputs, let the edge happen, push the model's
    // expectation, return at the following falling edge.
    task automatic cycle(input int rst, input int en, input int load,
                         input int mode, input int lim, input int din);
        exp_t e;
        RST   = (rst != 0);
        EN    = (en != 0);
        LOAD  = (load != 0);
        MODE  = 2'(mode);
        LIMIT = WIDTH'(lim);
        DIN   = WIDTH'(din);
        @(posedge CLK);
        model_edge(rst, en, load, mode, lim, din);
        cyc++;
        e.q = m_q; e.tick = m_tick; e.tc = m_tc; e.cyc = cyc;
        sbq.push_back(e);
        @(negedge CLK);
    endtask

    // Monitor: outputs are registered, so a new result is presented every cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("sb_Q", e.cyc, int'(Q), e.q);
            check("sb_TICK", e.cyc, int'(TICK), e.tick);
            check("sb_TC", e.cyc, int'(TC), e.tc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq1[7];
        int seq2[5];
        int seq3[7];
        int tc3[7];
        int mode_r, lim_r;
        seq1 = '{1, 2, 3, 4, 5, 0, 1};
        seq2 = '{3, 2, 1, 0, 3};
        seq3 = '{1, 2, 3, 2, 1, 0, 1};
        tc3  = '{0, 0, 0, 1, 0, 0, 1};

        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 5, 9);
        check("rst_Q", cyc, int'(Q), 0);
        check("rst_TICK", cyc, int'(TICK), 0);
        check("rst_TC", cyc, int'(TC), 0);

        // Up-wrap, LIMIT=5
        for (int i = 1; i <= 28; i++) begin
            cycle(0, 1, 0, 0, 5, 0);
            if (i % PERIOD == 0) begin
                check("up_Q", cyc, int'(Q), seq1[i/PERIOD-1]);
                check("up_TICK", cyc, int'(TICK), 1);
                check("up_TC", cyc, int'(TC), (seq1[i/PERIOD-1] == 0) ? 1 : 0);
            end else begin
                check("up_TICK_idle", cyc, int'(TICK), 0);
            end
        end

        // Down-wrap, LIMIT=3, loaded with 9
        cycle(0, 1, 1, 1, 3, 9);
        check("load9_Q", cyc, int'(Q), 9);
        for (int i = 1; i <= 20; i++) begin
            cycle(0, 1, 0, 1, 3, 0);
            if (i % PERIOD == 0) begin
                check("down_Q", cyc, int'(Q), seq2[i/PERIOD-1]);
                check("down_TC", cyc, int'(TC), (i == 20) ? 1 : 0);
            end
        end

        // Ping-pong, LIMIT=3, from reset
        cycle(1, 0, 0, 2, 3, 0);
        for (int i = 1; i <= 28; i++) begin
            cycle(0, 1, 0, 2, 3, 0);
            if (i % PERIOD == 0) begin
                check("pp_Q", cyc, int'(Q), seq3[i/PERIOD-1]);
                check("pp_TC", cyc, int'(TC), tc3[i/PERIOD-1]);
            end
        end

        // LOAD coincident with a step (Q is 1 here)
        for (int k = 0; k < 8 && m_phase != PERIOD - 1; k++) cycle(0, 1, 0, 0, 10, 0);
        cycle(0, 1, 1, 0, 10, 7);
        check("ldstep_Q", cyc, int'(Q), 7);
        check("ldstep_TC", cyc, int'(TC), 0);
        check("ldstep_TICK", cyc, int'(TICK), 0);
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 0, 0, 10, 0);
            check("ldstep_next_TICK", cyc, int'(TICK), (i == 4) ? 1 : 0);
        end
        check("ldstep_next_Q", cyc, int'(Q), 8);

        // EN dropped for 10 cycles mid-period
        cycle(0, 1, 0, 0, 15, 0);
        cycle(0, 1, 0, 0, 15, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, 15, 0);
            check("en0_Q", cyc, int'(Q), 8);
            check("en0_TICK", cyc, int'(TICK), 0);
            check("en0_TC", cyc, int'(TC), 0);
        end
        cycle(0, 1, 0, 0, 15, 0);
        check("resume_TICK_early", cyc, int'(TICK), 0);
        cycle(0, 1, 0, 0, 15, 0);
        check("resume_TICK", cyc, int'(TICK), 1);
        check("resume_Q", cyc, int'(Q), 9);

        // Reset while ping-pong is moving down through 6
        cycle(1, 0, 0, 2, 9, 0);
        for (int i = 0; i < 48; i++) cycle(0, 1, 0, 2, 9, 0);
        check("pp9_Q", cyc, int'(Q), 6);
        cycle(0, 1, 0, 2, 9, 0);
        cycle(0, 1, 0, 2, 9, 0);
        cycle(1, 1, 0, 2, 9, 0);
        check("midrst_Q", cyc, int'(Q), 0);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 0, 2, 9, 0);
            if (i == 4) check("midrst_first_Q", cyc, int'(Q), 1);
            if (i == 8) check("midrst_dir_up_Q", cyc, int'(Q), 2);
        end

        // Randomized traffic against the reference model
        mode_r = 0;
        lim_r  = 5;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) mode_r = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0)
                lim_r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
            cycle(($urandom_range(0, 63) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) != 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  mode_r, lim_r, $urandom_range(0, 15));
        end

        repeat (2) @(negedge CLK);
        #1;
        check("sb_drain", cyc, sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
